// File: rtl/dac_stream_pkg.sv
// Shared types and helpers for the multi-channel DAC interpolation stream.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dac_stream_pkg;

    // Stream controller states: wait for FIFO level, load second sample, stream out.
    typedef enum logic [1:0] {
        ST_FILL,
        ST_PRIME,
        ST_RUN
    } state_t;

    // Mid-scale code of an unsigned offset-binary sample of the given width.
    function automatic logic [31:0] midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    // LSB position of channel 'ch' inside a packed multi-channel word.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; rd_data shows the head entry combinationally.
// Latency: a written word is visible on rd_data the cycle after the write.
// Backpressure: none upstream; a write while full without a same-cycle pop is dropped and flagged on wr_drop.
module sync_fifo_fwft #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       wr_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;
    logic             do_push;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a write to a full FIFO is accepted alongside it.
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign wr_drop = wr_en && !do_push;

    // Storage array; no reset needed because pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; reset flushes the contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dac_interp_stream.sv
// Buffers packed DAC samples and upsamples each channel by 2^INTERP_SHIFT (hold or linear).
// Latency: dac_data registered one cycle after the computing RUN cycle; first valid 3 cycles after FILL exit.
// Backpressure: none; writes to a full FIFO are dropped (overflow), running dry drops to FILL (underrun).
module dac_interp_stream
    import dac_stream_pkg::*;
#(
    parameter int DATAWIDTH    = 14,
    parameter int NUM_CH       = 2,
    parameter int FIFO_DEPTH   = 64,
    parameter int INTERP_SHIFT = 2,
    parameter int START_LEVEL  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            mode,
    input  logic                            clr_flags,
    input  logic                            wr_en,
    input  logic [NUM_CH*DATAWIDTH-1:0]     wr_data,
    output logic                            fifo_full,
    output logic                            fifo_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic [NUM_CH*DATAWIDTH-1:0]     dac_data,
    output logic                            dac_valid,
    output logic                            overflow,
    output logic                            underrun
);
    localparam int W   = NUM_CH * DATAWIDTH;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = (INTERP_SHIFT == 0) ? 1 : INTERP_SHIFT;
    localparam int PRW = DATAWIDTH + PW + 2;

    localparam logic [PW-1:0]        LAST_PHASE = PW'((1 << INTERP_SHIFT) - 1);
    localparam logic [DATAWIDTH-1:0] MID        = DATAWIDTH'(midscale(DATAWIDTH));
    localparam logic [W-1:0]         MID_ALL    = {NUM_CH{MID}};
    localparam logic [CW-1:0]        START_CNT  = CW'(START_LEVEL);

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [W-1:0]  cur_q, cur_d;
    logic [W-1:0]  nxt_q, nxt_d;
    logic [W-1:0]  dac_data_q, dac_data_d;
    logic          dac_valid_q, dac_valid_d;
    logic          overflow_q, underrun_q;
    logic          underrun_evt;
    logic          pop;
    logic          wr_drop;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  y_lin;

    sync_fifo_fwft #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .wr_drop (wr_drop)
    );

    // Per channel: y = cur + floor((nxt - cur) * phase / 2^SHIFT); stays between cur and nxt.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam int LSB = int'(ch_lsb(g, DATAWIDTH));
        logic        [DATAWIDTH-1:0] c_s;
        logic        [DATAWIDTH-1:0] n_s;
        logic signed [DATAWIDTH:0]   diff;
        logic signed [PRW-1:0]       prod;
        logic signed [PRW-1:0]       step;

        assign c_s  = cur_q[LSB +: DATAWIDTH];
        assign n_s  = nxt_q[LSB +: DATAWIDTH];
        assign diff = $signed({1'b0, n_s}) - $signed({1'b0, c_s});
        assign prod = PRW'(diff) * PRW'($signed({1'b0, phase_q}));
        assign step = prod >>> INTERP_SHIFT;
        assign y_lin[LSB +: DATAWIDTH] = DATAWIDTH'({{(PRW - DATAWIDTH){1'b0}}, c_s} + step);
    end

    // Next-state, sample pipeline and output selection.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cur_d        = cur_q;
        nxt_d        = nxt_q;
        dac_data_d   = MID_ALL;
        dac_valid_d  = 1'b0;
        pop          = 1'b0;
        underrun_evt = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (en && (fifo_count >= START_CNT)) begin
                    pop     = 1'b1;
                    cur_d   = rd_data;
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                // START_LEVEL >= 2 guarantees a second word is present here.
                if (!en) begin
                    state_d = ST_FILL;
                end else begin
                    pop     = 1'b1;
                    nxt_d   = rd_data;
                    phase_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_FILL;
                end else begin
                    dac_valid_d = 1'b1;
                    dac_data_d  = mode ? y_lin : cur_q;
                    if (phase_q == LAST_PHASE) begin
                        phase_d = '0;
                        if (!fifo_empty) begin
                            pop   = 1'b1;
                            cur_d = nxt_q;
                            nxt_d = rd_data;
                        end else begin
                            underrun_evt = 1'b1;
                            state_d      = ST_FILL;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State, sample registers and registered DAC outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            phase_q     <= '0;
            cur_q       <= '0;
            nxt_q       <= '0;
            dac_data_q  <= MID_ALL;
            dac_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_flags wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end else if (clr_flags) begin
                overflow_q <= 1'b0;
            end
            if (underrun_evt) begin
                underrun_q <= 1'b1;
            end else if (clr_flags) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign dac_data  = dac_data_q;
    assign dac_valid = dac_valid_q;
    assign overflow  = overflow_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_dac_interp_stream.sv
// Bench for dac_interp_stream: directed ramps plus random streams against a sample-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dac_interp_stream;
    localparam int DW    = 14;
    localparam int NCH   = 2;
    localparam int DEPTH = 64;
    localparam int SH    = 2;
    localparam int START = 32;
    localparam int F     = 1 << SH;
    localparam int W     = NCH * DW;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef logic [W-1:0] word_t;
    localparam word_t MID_W = {NCH{14'h2000}};

    logic          clk;
    logic          rst;
    logic          en;
    logic          mode;
    logic          clr_flags;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [W-1:0]  dac_data;
    logic          dac_valid;
    logic          overflow;
    logic          underrun;

    dac_interp_stream #(
        .DATAWIDTH    (DW),
        .NUM_CH       (NCH),
        .FIFO_DEPTH   (DEPTH),
        .INTERP_SHIFT (SH),
        .START_LEVEL  (START)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .clr_flags  (clr_flags),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .dac_data   (dac_data),
        .dac_valid  (dac_valid),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    word_t smp_q[$];
    word_t exp_q[$];
    word_t out_q[$];

    // Every valid output sample is logged, sampled away from the active edge.
    always @(negedge clk) begin
        if (dac_valid === 1'b1) out_q.push_back(dac_data);
    end

    // Reference: hold repeats cur; linear steps from cur towards nxt in F equal floor-rounded parts.
    function automatic int interp(input int c, input int n, input int p, input bit lin);
        int num;
        int q;
        if (!lin) return c;
        num = (n - c) * p;
        q = num / F;
        if ((num % F) != 0 && num < 0) q = q - 1;
        return c + q;
    endfunction

    // Each adjacent pair of buffered samples yields F outputs; the last sample only closes a pair.
    task automatic build_expected(input bit lin);
        word_t a, b, w;
        exp_q.delete();
        for (int k = 0; k + 1 < smp_q.size(); k++) begin
            a = smp_q[k];
            b = smp_q[k+1];
            for (int p = 0; p < F; p++) begin
                w = '0;
                for (int ch = 0; ch < NCH; ch++)
                    w[ch*DW +: DW] = DW'(interp(int'(a[ch*DW +: DW]), int'(b[ch*DW +: DW]), p, lin));
                exp_q.push_back(w);
            end
        end
    endtask

    function automatic word_t rand_word();
        word_t w;
        for (int ch = 0; ch < NCH; ch++) w[ch*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
        return w;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; clr_flags = 1'b0; wr_en = 1'b0; wr_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic push_word(input word_t w);
        wr_data = w;
        wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Waits (bounded) for the first valid output; returns clocks counted from the last write edge.
    task automatic wait_valid(output int lat);
        int tries;
        lat = 0;
        tries = 0;
        while (lat == 0 && tries < 20) begin
            @(posedge clk); #1;
            tries++;
            if (dac_valid === 1'b1) lat = tries;
        end
    endtask

    // From reset: write smp_q with en high, measure first-output latency, let the stream drain.
    task automatic stream_from_empty(input bit lin, output int lat, output int base);
        do_reset();
        mode = lin;
        en = 1'b1;
        base = out_q.size();
        foreach (smp_q[i]) push_word(smp_q[i]);
        wait_valid(lat);
        cycles(F * smp_q.size() + 10);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", dac_valid); end
        n_cmp++; if (dac_data !== MID_W) begin n_err++; $display("FAIL reset_data got %h exp %h", dac_data, MID_W); end
        n_cmp++; if ({overflow, underrun} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b exp 00", {overflow, underrun}); end
        n_cmp++; if ({fifo_empty, fifo_full} !== 2'b10) begin n_err++; $display("FAIL reset_empty_full got %b exp 10", {fifo_empty, fifo_full}); end
        n_cmp++; if (fifo_count !== CW'(0)) begin n_err++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        en = 1'b1;
        for (int i = 0; i < START - 1; i++) push_word(rand_word());
        cycles(10);
        n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL fill31_valid got %b exp 0", dac_valid); end
        n_cmp++; if (dac_data !== MID_W) begin n_err++; $display("FAIL fill31_data got %h exp %h", dac_data, MID_W); end
        n_cmp++; if (fifo_count !== CW'(START - 1)) begin n_err++; $display("FAIL fill31_count got %0d exp %0d", fifo_count, START - 1); end
    endtask

    task automatic test_linear_ramp();
        int lat, base;
        word_t o;
        int ramp[8] = '{100, 125, 150, 175, 200, 225, 250, 275};
        smp_q.delete();
        for (int i = 0; i < START; i++) begin
            o = rand_word();
            o[DW-1:0] = DW'(100 * (i + 1));
            smp_q.push_back(o);
        end
        stream_from_empty(1'b1, lat, base);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL ramp_latency got %0d exp 3", lat); end
        for (int i = 0; i < 8; i++) begin
            o = (base + i < out_q.size()) ? out_q[base+i] : 'x;
            n_cmp++; if (o[DW-1:0] !== DW'(ramp[i])) begin n_err++; $display("FAIL ramp_ch0[%0d] got %0d exp %0d", i, o[DW-1:0], ramp[i]); end
        end
        build_expected(1'b1);
        n_cmp++; if (out_q.size() - base !== exp_q.size()) begin n_err++; $display("FAIL ramp_len got %0d exp %0d", out_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (base + i < out_q.size()) ? out_q[base+i] : 'x;
            n_cmp++; if (o !== exp_q[i]) begin n_err++; $display("FAIL ramp_out[%0d] got %h exp %h", i, o, exp_q[i]); end
        end
    endtask

    task automatic test_hold();
        int lat, base;
        word_t o;
        int hold[8] = '{100, 100, 100, 100, 200, 200, 200, 200};
        smp_q.delete();
        for (int i = 0; i < START; i++) begin
            o = rand_word();
            o[DW-1:0] = DW'(100 * (i + 1));
            smp_q.push_back(o);
        end
        stream_from_empty(1'b0, lat, base);
        for (int i = 0; i < 8; i++) begin
            o = (base + i < out_q.size()) ? out_q[base+i] : 'x;
            n_cmp++; if (o[DW-1:0] !== DW'(hold[i])) begin n_err++; $display("FAIL hold_ch0[%0d] got %0d exp %0d", i, o[DW-1:0], hold[i]); end
        end
        build_expected(1'b0);
        n_cmp++; if (out_q.size() - base !== exp_q.size()) begin n_err++; $display("FAIL hold_len got %0d exp %0d", out_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (base + i < out_q.size()) ? out_q[base+i] : 'x;
            n_cmp++; if (o !== exp_q[i]) begin n_err++; $display("FAIL hold_out[%0d] got %h exp %h", i, o, exp_q[i]); end
        end
    endtask

    task automatic test_descending();
        int lat, base;
        word_t o;
        int desc[5] = '{200, 175, 150, 125, 100};
        smp_q.delete();
        for (int i = 0; i < START; i++) begin
            o = rand_word();
            if (i == 0) o[DW-1:0] = DW'(200);
            if (i == 1) o[DW-1:0] = DW'(100);
            smp_q.push_back(o);
        end
        stream_from_empty(1'b1, lat, base);
        for (int i = 0; i < 5; i++) begin
            o = (base + i < out_q.size()) ? out_q[base+i] : 'x;
            n_cmp++; if (o[DW-1:0] !== DW'(desc[i])) begin n_err++; $display("FAIL desc_ch0[%0d] got %0d exp %0d", i, o[DW-1:0], desc[i]); end
        end
        build_expected(1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (base + i < out_q.size()) ? out_q[base+i] : 'x;
            n_cmp++; if (o !== exp_q[i]) begin n_err++; $display("FAIL desc_out[%0d] got %h exp %h", i, o, exp_q[i]); end
        end
    endtask

    task automatic test_random_streams();
        int lat, base;
        word_t o;
        bit lin;
        for (int r = 0; r < 3; r++) begin
            lin = 1'($urandom_range(0, 1));
            smp_q.delete();
            for (int i = 0; i < int'($urandom_range(START, START + 20)); i++) smp_q.push_back(rand_word());
            stream_from_empty(lin, lat, base);
            build_expected(lin);
            n_cmp++; if (out_q.size() - base !== exp_q.size()) begin n_err++; $display("FAIL rand%0d_len got %0d exp %0d", r, out_q.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                o = (base + i < out_q.size()) ? out_q[base+i] : 'x;
                n_cmp++; if (o !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_out[%0d] got %h exp %h mode %0d", r, i, o, exp_q[i], lin); end
            end
        end
    endtask

    // Writes keep trickling in while the stream consumes, so pushes coincide with pops.
    task automatic test_back_to_back();
        int base;
        word_t o;
        do_reset();
        mode = 1'b1;
        en = 1'b1;
        base = out_q.size();
        smp_q.delete();
        for (int i = 0; i < 60; i++) smp_q.push_back(rand_word());
        for (int i = 0; i < 36; i++) push_word(smp_q[i]);
        for (int i = 36; i < 60; i++) begin
            push_word(smp_q[i]);
            cycles(int'($urandom_range(1, 3)));
        end
        cycles(F * 60 + 20);
        build_expected(1'b1);
        n_cmp++; if (out_q.size() - base !== exp_q.size()) begin n_err++; $display("FAIL b2b_len got %0d exp %0d", out_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (base + i < out_q.size()) ? out_q[base+i] : 'x;
            n_cmp++; if (o !== exp_q[i]) begin n_err++; $display("FAIL b2b_out[%0d] got %h exp %h", i, o, exp_q[i]); end
        end
        n_cmp++; if ({overflow, underrun} !== 2'b01) begin n_err++; $display("FAIL b2b_flags got %b exp 01", {overflow, underrun}); end
    endtask

    task automatic test_underrun_resume();
        int lat, base;
        word_t o;
        smp_q.delete();
        for (int i = 0; i < START; i++) smp_q.push_back(rand_word());
        stream_from_empty(1'b1, lat, base);
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_flag got %b exp 1", underrun); end
        n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL ur_valid got %b exp 0", dac_valid); end
        n_cmp++; if (dac_data !== MID_W) begin n_err++; $display("FAIL ur_data got %h exp %h", dac_data, MID_W); end
        smp_q.delete();
        for (int i = 0; i < START; i++) smp_q.push_back(rand_word());
        base = out_q.size();
        for (int i = 0; i < START - 1; i++) push_word(smp_q[i]);
        cycles(5);
        n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL refill_valid got %b exp 0", dac_valid); end
        n_cmp++; if (fifo_count !== CW'(START - 1)) begin n_err++; $display("FAIL refill_count got %0d exp %0d", fifo_count, START - 1); end
        push_word(smp_q[START-1]);
        wait_valid(lat);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL resume_latency got %0d exp 3", lat); end
        cycles(F * START + 10);
        build_expected(1'b1);
        n_cmp++; if (out_q.size() - base !== exp_q.size()) begin n_err++; $display("FAIL resume_len got %0d exp %0d", out_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (base + i < out_q.size()) ? out_q[base+i] : 'x;
            n_cmp++; if (o !== exp_q[i]) begin n_err++; $display("FAIL resume_out[%0d] got %h exp %h", i, o, exp_q[i]); end
        end
        clr_flags = 1'b1; @(posedge clk); #1; clr_flags = 1'b0;
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_clear got %b exp 0", underrun); end
    endtask

    task automatic test_overflow();
        int base;
        word_t o;
        do_reset();
        smp_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) smp_q.push_back(rand_word());
        foreach (smp_q[i]) push_word(smp_q[i]);
        n_cmp++; if (fifo_count !== CW'(DEPTH)) begin n_err++; $display("FAIL ovf_count got %0d exp %0d", fifo_count, DEPTH); end
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b exp 1", fifo_full); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        clr_flags = 1'b1;
        push_word(rand_word());
        clr_flags = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_clr_vs_err got %b exp 1", overflow); end
        clr_flags = 1'b1; @(posedge clk); #1; clr_flags = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        void'(smp_q.pop_back());
        mode = 1'b0;
        en = 1'b1;
        base = out_q.size();
        cycles(F * DEPTH + 20);
        build_expected(1'b0);
        n_cmp++; if (out_q.size() - base !== exp_q.size()) begin n_err++; $display("FAIL ovf_len got %0d exp %0d", out_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (base + i < out_q.size()) ? out_q[base+i] : 'x;
            n_cmp++; if (o !== exp_q[i]) begin n_err++; $display("FAIL ovf_out[%0d] got %h exp %h", i, o, exp_q[i]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < 40; i++) push_word(rand_word());
        cycles(20);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b exp 0", dac_valid); end
        n_cmp++; if (dac_data !== MID_W) begin n_err++; $display("FAIL arst_data got %h exp %h", dac_data, MID_W); end
        n_cmp++; if (fifo_count !== CW'(0) || fifo_empty !== 1'b1) begin n_err++; $display("FAIL arst_fifo got count %0d empty %b exp 0 1", fifo_count, fifo_empty); end
        @(posedge clk); #1;
        rst = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; clr_flags = 1'b0; wr_en = 1'b0; wr_data = '0;
        test_reset();
        test_linear_ramp();
        test_hold();
        test_descending();
        test_random_streams();
        test_back_to_back();
        test_underrun_resume();
        test_overflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
